// File: rtl/fft_r2_stage_engine.sv
// Radix-2 DIT butterfly engine: executes all N/2 butterflies of one FFT stage in place.
// Optional FFT_STAGE_SCALE_EN halves A+t / A-t before saturation (1/N scaling over a full FFT).
//
// state | meaning
// IDLE  | wait for start, latch stage index
// RDA   | present a address and twiddle index
// RDB   | capture A and twiddle, present b address
// MUL   | t = B*W, rounded, registered
// WRA   | write sat(A + t) to a
// WRB   | write sat(A - t) to b, advance k or finish
// FIN   | done pulse
// ERR   | done + err pulse, stage index out of range
module fft_r2_stage_engine #(
    parameter int LOG2N  = 6,
    parameter int DATA_W = 16,
    parameter int TW_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        stage,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LOG2N-1:0]  mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata_re,
    output logic [DATA_W-1:0] mem_wdata_im,
    input  logic [DATA_W-1:0] mem_rdata_re,
    input  logic [DATA_W-1:0] mem_rdata_im,
    output logic [LOG2N-2:0]  tw_addr,
    input  logic [TW_W-1:0]   tw_cos,
    input  logic [TW_W-1:0]   tw_sin
);
    localparam int KW  = LOG2N - 1;
    localparam int PW  = DATA_W + TW_W + 1;
    localparam int TDW = DATA_W + 2;
    localparam int SW  = DATA_W + 3;
    localparam logic signed [PW-1:0] RND     = PW'(1) << (TW_W - 2);
    localparam logic signed [SW-1:0] SAT_MAX = {4'b0000, {(DATA_W-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE, S_RDA, S_RDB, S_MUL, S_WRA, S_WRB, S_FIN, S_ERR
    } state_t;

    state_t                   state_q, state_d;
    logic [KW-1:0]            k_q, k_d;
    logic [4:0]               stage_q, stage_d;
    logic signed [DATA_W-1:0] a_re_q, a_re_d, a_im_q, a_im_d;
    logic signed [TW_W-1:0]   cos_q, cos_d, sin_q, sin_d;
    logic signed [TDW-1:0]    t_re_q, t_re_d, t_im_q, t_im_d;

    logic signed [PW-1:0]     b_re_x, b_im_x, cos_x, sin_x, acc_re, acc_im;
    logic [LOG2N-1:0]         k_ext, half, j, idx_a, idx_b;
    logic [KW-1:0]            tw_idx;
    logic signed [SW-1:0]     a_re_x, a_im_x, t_re_x, t_im_x;
    logic signed [SW-1:0]     sum_re, sum_im, dif_re, dif_im;

    function automatic logic [DATA_W-1:0] sat(input logic signed [SW-1:0] v);
        if (v > SAT_MAX) return DATA_W'(SAT_MAX);
        else if (v < SAT_MIN) return DATA_W'(SAT_MIN);
        return DATA_W'(v);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            stage_q <= '0;
            a_re_q  <= '0;
            a_im_q  <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
            t_re_q  <= '0;
            t_im_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            stage_q <= stage_d;
            a_re_q  <= a_re_d;
            a_im_q  <= a_im_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
            t_re_q  <= t_re_d;
            t_im_q  <= t_im_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stage_d = stage_q;
        a_re_d  = a_re_q;
        a_im_d  = a_im_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        t_re_d  = t_re_q;
        t_im_d  = t_im_q;
        // In MUL the RAM read port is returning B
        b_re_x  = PW'($signed(mem_rdata_re));
        b_im_x  = PW'($signed(mem_rdata_im));
        cos_x   = PW'(cos_q);
        sin_x   = PW'(sin_q);
        acc_re  = b_re_x * cos_x + b_im_x * sin_x + RND;
        acc_im  = b_im_x * cos_x - b_re_x * sin_x + RND;
        case (state_q)
            S_IDLE: begin
                k_d = '0;
                if (start) begin
                    stage_d = stage;
                    state_d = (stage < 5'(LOG2N)) ? S_RDA : S_ERR;
                end
            end
            S_RDA: state_d = S_RDB;
            S_RDB: begin
                a_re_d  = $signed(mem_rdata_re);
                a_im_d  = $signed(mem_rdata_im);
                cos_d   = $signed(tw_cos);
                sin_d   = $signed(tw_sin);
                state_d = S_MUL;
            end
            S_MUL: begin
                t_re_d  = TDW'(acc_re >>> (TW_W - 1));
                t_im_d  = TDW'(acc_im >>> (TW_W - 1));
                state_d = S_WRA;
            end
            S_WRA: state_d = S_WRB;
            S_WRB: begin
                if (k_q == {KW{1'b1}}) begin
                    state_d = S_FIN;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = S_RDA;
                end
            end
            S_FIN:   state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        k_ext  = {1'b0, k_q};
        half   = LOG2N'(1) << stage_q;
        j      = k_ext & (half - LOG2N'(1));
        idx_a  = ((k_ext >> stage_q) << (stage_q + 5'd1)) | j;
        idx_b  = idx_a | half;
        tw_idx = KW'(j) << (5'(KW) - stage_q);
        a_re_x = SW'(a_re_q);
        a_im_x = SW'(a_im_q);
        t_re_x = SW'(t_re_q);
        t_im_x = SW'(t_im_q);
        sum_re = a_re_x + t_re_x;
        sum_im = a_im_x + t_im_x;
        dif_re = a_re_x - t_re_x;
        dif_im = a_im_x - t_im_x;
`ifdef FFT_STAGE_SCALE_EN
        sum_re = sum_re >>> 1;
        sum_im = sum_im >>> 1;
        dif_re = dif_re >>> 1;
        dif_im = dif_im >>> 1;
`endif
        busy         = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        tw_addr      = '0;
        mem_wdata_re = '0;
        mem_wdata_im = '0;
        case (state_q)
            S_RDA: begin
                busy     = 1'b1;
                mem_addr = idx_a;
                tw_addr  = tw_idx;
            end
            S_RDB, S_MUL: begin
                busy     = 1'b1;
                mem_addr = idx_b;
            end
            S_WRA: begin
                busy         = 1'b1;
                mem_we       = 1'b1;
                mem_addr     = idx_a;
                mem_wdata_re = sat(sum_re);
                mem_wdata_im = sat(sum_im);
            end
            S_WRB: begin
                busy         = 1'b1;
                mem_we       = 1'b1;
                mem_addr     = idx_b;
                mem_wdata_re = sat(dif_re);
                mem_wdata_im = sat(dif_im);
            end
            S_FIN: done = 1'b1;
            S_ERR: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_fft_r2_stage_engine.sv
// Bench for fft_r2_stage_engine (N=8): butterfly-level reference model, per-cycle bus compare,
// RAM/ROM models, literal scenario checks. Honours FFT_STAGE_SCALE_EN if defined.
module tb_fft_r2_stage_engine;
    localparam int LOG2N = 3;
    localparam int N     = 8;
    localparam int H     = 4;
    localparam int TOT   = 5 * H;

`ifdef FFT_STAGE_SCALE_EN
    localparam int E1A = 600,   E1B = 400,   E2A = 500,  E2B = -500;
    localparam int E3A = 20000, E3B = 10000;
`else
    localparam int E1A = 1200,  E1B = 800,   E2A = 1000, E2B = -1000;
    localparam int E3A = 32767, E3B = 20000;
`endif

    logic        clk, rst, start;
    logic [4:0]  stage;
    logic        busy, done, err, mem_we;
    logic [2:0]  mem_addr;
    logic [15:0] mem_wdata_re, mem_wdata_im;
    logic signed [15:0] rd_re, rd_im, tc, ts;
    logic [1:0]  tw_addr;

    logic signed [15:0] ram_re[N], ram_im[N];
    logic signed [15:0] tw_cos[H], tw_sin[H];
    logic        pre_we;
    logic [2:0]  pre_addr;
    logic signed [15:0] pre_re, pre_im;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_a[H], exp_b[H], exp_tw[H], exp_ar[H], exp_ai[H], exp_br[H], exp_bi[H];
    int mre[N], mim[N];
    int wr_log[$];
    int run_cyc = -1;
    bit run_err = 0;
    int cmp_k, cmp_ph;

    fft_r2_stage_engine #(.LOG2N(LOG2N), .DATA_W(16), .TW_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stage(stage),
        .busy(busy), .done(done), .err(err),
        .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata_re(mem_wdata_re), .mem_wdata_im(mem_wdata_im),
        .mem_rdata_re(rd_re), .mem_rdata_im(rd_im),
        .tw_addr(tw_addr), .tw_cos(tc), .tw_sin(ts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) begin
            ram_re[pre_addr] <= pre_re;
            ram_im[pre_addr] <= pre_im;
        end else if (mem_we) begin
            ram_re[mem_addr] <= mem_wdata_re;
            ram_im[mem_addr] <= mem_wdata_im;
        end
        rd_re <= ram_re[mem_addr];
        rd_im <= ram_im[mem_addr];
        tc    <= tw_cos[tw_addr];
        ts    <= tw_sin[tw_addr];
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    // Butterflies enumerated as (group, offset) pairs from the current RAM/ROM contents
    task automatic build_model(input int s);
        int k;
        for (int i = 0; i < N; i++) begin
            mre[i] = ram_re[i];
            mim[i] = ram_im[i];
        end
        if (s >= LOG2N) return;
        k = 0;
        for (int g = 0; g < N / (2 << s); g++) begin
            for (int jj = 0; jj < (1 << s); jj++) begin
                int a = g * (2 << s) + jj;
                int b = a + (1 << s);
                int w = jj * (N / (2 << s));
                longint c  = tw_cos[w];
                longint sn = tw_sin[w];
                longint ar = ram_re[a], ai = ram_im[a];
                longint br = ram_re[b], bi = ram_im[b];
                longint tr = (br * c + bi * sn + 16384) >>> 15;
                longint ti = (bi * c - br * sn + 16384) >>> 15;
                longint pr = ar + tr, pim = ai + ti, dr = ar - tr, dim = ai - ti;
`ifdef FFT_STAGE_SCALE_EN
                pr = pr >>> 1; pim = pim >>> 1; dr = dr >>> 1; dim = dim >>> 1;
`endif
                exp_a[k]  = a;
                exp_b[k]  = b;
                exp_tw[k] = w;
                exp_ar[k] = sat16(pr);
                exp_ai[k] = sat16(pim);
                exp_br[k] = sat16(dr);
                exp_bi[k] = sat16(dim);
                mre[a] = exp_ar[k]; mim[a] = exp_ai[k];
                mre[b] = exp_br[k]; mim[b] = exp_bi[k];
                k++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
            chk("rst_we", mem_we, 0);
            chk("rst_addr", mem_addr, 0);
            chk("rst_tw", tw_addr, 0);
            chk("rst_wre", mem_wdata_re, 0);
            chk("rst_wim", mem_wdata_im, 0);
            run_cyc = -1;
            run_err = 0;
        end else if (run_cyc >= 0) begin
            if (run_err) begin
                chk("err_done", done, 1);
                chk("err_err", err, 1);
                chk("err_we", mem_we, 0);
                chk("err_busy", busy, 0);
                run_cyc = -1;
            end else if (run_cyc < TOT) begin
                cmp_k  = run_cyc / 5;
                cmp_ph = run_cyc % 5;
                chk("run_busy", busy, 1);
                chk("run_done", done, 0);
                chk("run_err", err, 0);
                case (cmp_ph)
                    0: begin
                        chk("rda_addr", mem_addr, exp_a[cmp_k]);
                        chk("rda_tw", tw_addr, exp_tw[cmp_k]);
                        chk("rda_we", mem_we, 0);
                    end
                    1: begin
                        chk("rdb_addr", mem_addr, exp_b[cmp_k]);
                        chk("rdb_we", mem_we, 0);
                    end
                    2: chk("mul_we", mem_we, 0);
                    3: begin
                        chk("wra_we", mem_we, 1);
                        chk("wra_addr", mem_addr, exp_a[cmp_k]);
                        chk("wra_re", $signed(mem_wdata_re), exp_ar[cmp_k]);
                        chk("wra_im", $signed(mem_wdata_im), exp_ai[cmp_k]);
                    end
                    default: begin
                        chk("wrb_we", mem_we, 1);
                        chk("wrb_addr", mem_addr, exp_b[cmp_k]);
                        chk("wrb_re", $signed(mem_wdata_re), exp_br[cmp_k]);
                        chk("wrb_im", $signed(mem_wdata_im), exp_bi[cmp_k]);
                    end
                endcase
                run_cyc++;
            end else begin
                chk("fin_done", done, 1);
                chk("fin_busy", busy, 0);
                chk("fin_err", err, 0);
                chk("fin_we", mem_we, 0);
                run_cyc = -1;
            end
        end else begin
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_err", err, 0);
            chk("idle_we", mem_we, 0);
            if (start) begin
                run_cyc = 0;
                run_err = (stage >= LOG2N);
            end
        end
        if (mem_we) wr_log.push_back(int'(mem_addr));
    end

    task automatic load(input int addr, input int re, input int im);
        pre_addr = 3'(addr);
        pre_re   = 16'(re);
        pre_im   = 16'(im);
        pre_we   = 1'b1;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic clear_ram();
        for (int i = 0; i < N; i++) load(i, 0, 0);
    endtask

    task automatic random_ram();
        for (int i = 0; i < N; i++) load(i, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    endtask

    task automatic default_tw();
        tw_cos[0] = 16'sd32767;  tw_sin[0] = 16'sd0;
        tw_cos[1] = 16'sd23170;  tw_sin[1] = 16'sd23170;
        tw_cos[2] = 16'sd0;      tw_sin[2] = 16'sd32767;
        tw_cos[3] = -16'sd23170; tw_sin[3] = 16'sd23170;
    endtask

    task automatic check_ram(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_ram%0d_re", tag, i), ram_re[i], mre[i]);
            chk($sformatf("%s_ram%0d_im", tag, i), ram_im[i], mim[i]);
        end
    endtask

    task automatic do_stage(input int s, input int poke, output int lat);
        bit got_done;
        build_model(s);
        @(posedge clk);
        #1 start = 1'b1; stage = 5'(s);
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        got_done = 0;
        while (lat < 200 && !got_done) begin
            @(negedge clk);
            lat++;
            if (poke != 0 && lat == poke) begin
                start = 1'b1;
                stage = 5'd0;
            end else if (poke != 0 && lat == poke + 1) begin
                start = 1'b0;
            end
            if (done) got_done = 1;
        end
        if (!got_done) chk("done_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int base;
        int seq[8];
        seq = '{0, 2, 1, 3, 4, 6, 5, 7};
        rst = 1'b1; start = 1'b0; stage = 5'd0;
        pre_we = 1'b0; pre_addr = 3'd0; pre_re = 16'sd0; pre_im = 16'sd0;
        default_tw();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        clear_ram();
        load(0, 1000, 0);
        load(1, 200, 0);
        do_stage(0, 0, lat);
        chk("t1_latency", lat, 5 * H + 1);
        check_ram("t1");
        chk("t1_ram0_re", ram_re[0], E1A);
        chk("t1_ram0_im", ram_im[0], 0);
        chk("t1_ram1_re", ram_re[1], E1B);
        chk("t1_ram1_im", ram_im[1], 0);

        clear_ram();
        load(6, 0, 1000);
        do_stage(2, 0, lat);
        chk("t2_latency", lat, 5 * H + 1);
        chk("t2_model_tw_k2", exp_tw[2], 2);
        check_ram("t2");
        chk("t2_ram2_re", ram_re[2], E2A);
        chk("t2_ram2_im", ram_im[2], 0);
        chk("t2_ram6_re", ram_re[6], E2B);
        chk("t2_ram6_im", ram_im[6], 0);

        clear_ram();
        load(0, 30000, 0);
        load(1, 10000, 0);
        do_stage(0, 0, lat);
        check_ram("t3");
        chk("t3_ram0_re", ram_re[0], E3A);
        chk("t3_ram1_re", ram_re[1], E3B);

        random_ram();
        base = wr_log.size();
        do_stage(1, 7, lat);
        chk("t4_latency", lat, 5 * H + 1);
        check_ram("t4");
        chk("t4_nwrites", wr_log.size() - base, 8);
        for (int i = 0; i < 8; i++)
            if (base + i < wr_log.size()) chk($sformatf("t4_wr%0d", i), wr_log[base + i], seq[i]);

        base = wr_log.size();
        do_stage(5, 0, lat);
        chk("t5_latency", lat, 1);
        chk("t5_nwrites", wr_log.size() - base, 0);
        check_ram("t5");

        for (int r = 0; r < 12; r++) begin
            random_ram();
            if (r % 2 == 1) begin
                for (int w = 0; w < H; w++) begin
                    tw_cos[w] = 16'($urandom_range(0, 65535));
                    tw_sin[w] = 16'($urandom_range(0, 65535));
                end
            end else begin
                default_tw();
            end
            do_stage(int'($urandom_range(0, LOG2N - 1)), 0, lat);
            chk("rnd_latency", lat, 5 * H + 1);
            check_ram("rnd");
        end
        default_tw();

        random_ram();
        build_model(0);
        @(posedge clk);
        #1 start = 1'b1; stage = 5'd0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        chk("t6_we_before_rst", mem_we, 1);
        rst = 1'b1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_err", err, 0);
        chk("t6_we", mem_we, 0);
        chk("t6_addr", mem_addr, 0);
        chk("t6_tw", tw_addr, 0);
        chk("t6_wre", mem_wdata_re, 0);
        chk("t6_wim", mem_wdata_im, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        do_stage(0, 0, lat);
        chk("t6_latency", lat, 5 * H + 1);
        check_ram("t6");

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
